// File: rtl/gpmc_wb_pkg.sv
// Shared types and helpers for the GPMC-to-Wishbone bridge.
package gpmc_wb_pkg;

    // Bridge transaction state.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        WR_REQ  = 3'd2,
        RD_REQ  = 3'd3,
        RD_HOLD = 3'd4,
        DONE    = 3'd5
    } state_t;

    // Read data presented to the host when the slave errors or never answers.
    localparam logic [15:0] DEFAULT_ERR_DATA = 16'hDEAD;

    // Width of a counter that must be able to hold the value 'cycles'.
    function automatic int timeout_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gpmc_wb_bridge_sync_in_sync.sv
// Multi-stage synchroniser for the GPMC control strobes and AD bus, plus a
// rising-edge detector on the synchronised GPMC clock.
module gpmc_in_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  gpmc_clk,
    input  logic                  gpmc_advn,
    input  logic                  gpmc_csn,
    input  logic                  gpmc_wein,
    input  logic                  gpmc_oen,
    input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
    output logic                  advn_s,
    output logic                  csn_s,
    output logic                  wein_s,
    output logic                  oen_s,
    output logic [DATA_WIDTH-1:0] ad_s,
    output logic                  gclk_rise
);

    // Packed as {oen, wein, csn, advn, gpmc_clk}; strobes idle high, clock low.
    localparam int              CW         = 5;
    localparam logic [CW-1:0]   CTRL_RESET = 5'b11110;

    logic [CW-1:0] ctrl_in;
    logic [CW-1:0] ctrl_last;
    logic          clk_prev_reg;

    assign ctrl_in = {gpmc_oen, gpmc_wein, gpmc_csn, gpmc_advn, gpmc_clk};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            logic [CW-1:0]         ctrl_reg;
            logic [DATA_WIDTH-1:0] ad_reg;
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous pad signals.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        ctrl_reg <= CTRL_RESET;
                        ad_reg   <= '0;
                    end else begin
                        ctrl_reg <= ctrl_in;
                        ad_reg   <= gpmc_ad_in;
                    end
                end
            end else begin : g_next
                // Later stages just shift the previous stage along.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        ctrl_reg <= CTRL_RESET;
                        ad_reg   <= '0;
                    end else begin
                        ctrl_reg <= g_stage[gi-1].ctrl_reg;
                        ad_reg   <= g_stage[gi-1].ad_reg;
                    end
                end
            end
        end
    endgenerate

    assign ctrl_last = g_stage[SYNC_STAGES-1].ctrl_reg;
    assign ad_s      = g_stage[SYNC_STAGES-1].ad_reg;
    assign oen_s     = ctrl_last[4];
    assign wein_s    = ctrl_last[3];
    assign csn_s     = ctrl_last[2];
    assign advn_s    = ctrl_last[1];

    // Remember the previous synchronised GPMC clock level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_prev_reg <= 1'b0;
        end else begin
            clk_prev_reg <= ctrl_last[0];
        end
    end

    assign gclk_rise = ctrl_last[0] & ~clk_prev_reg;

endmodule

// File: rtl/gpmc_wb_bridge_sync.sv
// GPMC-to-Wishbone master bridge: oversamples the GPMC bus in the clk domain,
// runs one Wishbone transfer per GPMC access and stalls the host meanwhile.
module gpmc_wb_bridge_sync
    import gpmc_wb_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 16,
    parameter int          DATA_WIDTH      = 16,
    parameter int          SYNC_STAGES     = 2,
    parameter int          TIMEOUT_CYCLES  = 255,
    parameter logic [15:0] ERR_DATA        = DEFAULT_ERR_DATA,
    parameter int          WAIT_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   gpmc_ad_in,
    output logic [DATA_WIDTH-1:0]   gpmc_ad_out,
    output logic                    gpmc_ad_oe,
    input  logic                    gpmc_clk,
    input  logic                    gpmc_advn,
    input  logic                    gpmc_csn,
    input  logic                    gpmc_wein,
    input  logic                    gpmc_oen,
    output logic                    gpmc_wait,
    output logic [ADDR_WIDTH-1:0]   wbm_address,
    output logic [DATA_WIDTH-1:0]   wbm_writedata,
    input  logic [DATA_WIDTH-1:0]   wbm_readdata,
    output logic [DATA_WIDTH/8-1:0] wbm_sel,
    output logic                    wbm_write,
    output logic                    wbm_strobe,
    output logic                    wbm_cycle,
    input  logic                    wbm_ack,
    input  logic                    wbm_err,
    output logic                    bus_error
);

    localparam int                    CNT_W      = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA_W = ERR_DATA[DATA_WIDTH-1:0];
    // Pin level of gpmc_wait when the host is not being stalled.
    localparam logic                  WAIT_IDLE  = (WAIT_ACTIVE_LOW != 0);

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic [ADDR_WIDTH-1:0]   address_reg;
    logic [DATA_WIDTH-1:0]   writedata_reg;
    logic [DATA_WIDTH-1:0]   ad_out_reg;
    logic                    oe_reg;
    logic                    wait_pin_reg;
    logic                    bus_error_reg;

    logic                    advn_s, csn_s, wein_s, oen_s, gclk_rise;
    logic [DATA_WIDTH-1:0]   ad_s;
    logic [ADDR_WIDTH-1:0]   addr_capture;

    logic                    in_req;
    logic                    timeout_hit;
    logic                    wb_done;
    logic                    wb_fail;
    logic                    cyc_comb, we_comb, oe_next, stall_next;

    gpmc_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_in_sync (
        .clk        (clk),
        .reset      (reset),
        .gpmc_clk   (gpmc_clk),
        .gpmc_advn  (gpmc_advn),
        .gpmc_csn   (gpmc_csn),
        .gpmc_wein  (gpmc_wein),
        .gpmc_oen   (gpmc_oen),
        .gpmc_ad_in (gpmc_ad_in),
        .advn_s     (advn_s),
        .csn_s      (csn_s),
        .wein_s     (wein_s),
        .oen_s      (oen_s),
        .ad_s       (ad_s),
        .gclk_rise  (gclk_rise)
    );

    // Address comes from the low bits of AD, zero-extended if the bus is narrower.
    generate
        if (ADDR_WIDTH <= DATA_WIDTH) begin : g_addr_trunc
            assign addr_capture = ad_s[ADDR_WIDTH-1:0];
        end else begin : g_addr_ext
            assign addr_capture = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, ad_s};
        end
    endgenerate

    assign in_req      = (state_reg == WR_REQ) || (state_reg == RD_REQ);
    assign timeout_hit = (cnt_reg == CNT_LAST);
    assign wb_done     = wbm_ack || wbm_err || timeout_hit;
    // Error wins over a simultaneous ack; a late ack on the timeout cycle still counts.
    assign wb_fail     = wbm_err || (!wbm_ack && timeout_hit);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, driven only by synchronised GPMC inputs.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (!csn_s && !advn_s && gclk_rise) state_next = ADDR;
            end
            ADDR: begin
                if (csn_s) begin
                    state_next = IDLE;
                end else if (advn_s && !wein_s) begin
                    // A pending write blocks the read path even before its clock edge.
                    if (gclk_rise) state_next = WR_REQ;
                end else if (advn_s && !oen_s) begin
                    state_next = RD_REQ;
                end
            end
            WR_REQ:  if (wb_done) state_next = DONE;
            RD_REQ:  if (wb_done) state_next = RD_HOLD;
            RD_HOLD: if (csn_s || oen_s) state_next = DONE;
            DONE:    if (csn_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: bus strobes follow the state, pad controls look one state ahead.
    always_comb begin
        cyc_comb   = 1'b0;
        we_comb    = 1'b0;
        case (state_reg)
            WR_REQ: begin
                cyc_comb = 1'b1;
                we_comb  = 1'b1;
            end
            RD_REQ:  cyc_comb = 1'b1;
            default: ;
        endcase
        stall_next = (state_next == WR_REQ) || (state_next == RD_REQ);
        oe_next    = (state_next == RD_HOLD) && !csn_s && !oen_s;
    end

    // Datapath registers: captured address/data, read-back data, timeout counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg       <= '0;
            address_reg   <= '0;
            writedata_reg <= '0;
            ad_out_reg    <= '0;
            oe_reg        <= 1'b0;
            wait_pin_reg  <= WAIT_IDLE;
            bus_error_reg <= 1'b0;
        end else begin
            oe_reg        <= oe_next;
            wait_pin_reg  <= stall_next ^ WAIT_IDLE;
            bus_error_reg <= in_req && wb_fail;
            if (state_reg == IDLE && state_next == ADDR) begin
                address_reg <= addr_capture;
            end
            if (state_reg == ADDR && state_next == WR_REQ) begin
                writedata_reg <= ad_s;
            end
            if (state_reg == RD_REQ && wb_done) begin
                ad_out_reg <= wb_fail ? ERR_DATA_W : wbm_readdata;
            end
            if (in_req) begin
                if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign wbm_cycle     = cyc_comb;
    assign wbm_strobe    = cyc_comb;
    assign wbm_write     = we_comb;
    assign wbm_address   = address_reg;
    assign wbm_writedata = writedata_reg;
    assign wbm_sel       = '1;
    assign gpmc_ad_out   = ad_out_reg;
    assign gpmc_ad_oe    = oe_reg;
    assign gpmc_wait     = wait_pin_reg;
    assign bus_error     = bus_error_reg;

endmodule

// File: tb/tb_gpmc_wb_bridge_sync.sv
// Directed bench for gpmc_wb_bridge_sync: GPMC host tasks, a scripted
// Wishbone slave and a negedge monitor feeding hand-computed checks.
module tb_gpmc_wb_bridge_sync;
    import gpmc_wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] gpmc_ad_in = '0;
    logic [15:0] gpmc_ad_out;
    logic        gpmc_ad_oe;
    logic        gpmc_clk = 1'b0;
    logic        gpmc_advn = 1'b1;
    logic        gpmc_csn = 1'b1;
    logic        gpmc_wein = 1'b1;
    logic        gpmc_oen = 1'b1;
    logic        gpmc_wait;
    logic [15:0] wbm_address;
    logic [15:0] wbm_writedata;
    logic [15:0] wbm_readdata = '0;
    logic [1:0]  wbm_sel;
    logic        wbm_write;
    logic        wbm_strobe;
    logic        wbm_cycle;
    logic        wbm_ack = 1'b0;
    logic        wbm_err = 1'b0;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    // Slave script: 0 none, 1 ack, 2 err, 3 ack+err; responds when the cycle is slave_lat clocks old.
    int slave_mode = 0;
    int slave_lat  = 1;
    int req_age    = 0;

    // Monitor results.
    int          cyc_rises, cyc_cycles, wait_cycles, err_cycles;
    logic        cyc_prev = 1'b0;
    logic [15:0] addr_seen, data_seen;
    logic        we_seen;

    gpmc_wb_bridge_sync #(
        .ADDR_WIDTH      (16),
        .DATA_WIDTH      (16),
        .SYNC_STAGES     (2),
        .TIMEOUT_CYCLES  (8),
        .ERR_DATA        (16'hDEAD),
        .WAIT_ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gpmc_ad_in    (gpmc_ad_in),
        .gpmc_ad_out   (gpmc_ad_out),
        .gpmc_ad_oe    (gpmc_ad_oe),
        .gpmc_clk      (gpmc_clk),
        .gpmc_advn     (gpmc_advn),
        .gpmc_csn      (gpmc_csn),
        .gpmc_wein     (gpmc_wein),
        .gpmc_oen      (gpmc_oen),
        .gpmc_wait     (gpmc_wait),
        .wbm_address   (wbm_address),
        .wbm_writedata (wbm_writedata),
        .wbm_readdata  (wbm_readdata),
        .wbm_sel       (wbm_sel),
        .wbm_write     (wbm_write),
        .wbm_strobe    (wbm_strobe),
        .wbm_cycle     (wbm_cycle),
        .wbm_ack       (wbm_ack),
        .wbm_err       (wbm_err),
        .bus_error     (bus_error)
    );

    always #5 clk = ~clk;

    // Wishbone slave and bus monitor, both on the falling edge.
    always @(negedge clk) begin
        if (wbm_cycle && wbm_strobe) req_age = req_age + 1;
        else req_age = 0;
        wbm_ack = ((slave_mode == 1) || (slave_mode == 3)) && (req_age == slave_lat);
        wbm_err = ((slave_mode == 2) || (slave_mode == 3)) && (req_age == slave_lat);
        if (wbm_cycle && !cyc_prev) cyc_rises = cyc_rises + 1;
        if (wbm_cycle) begin
            cyc_cycles = cyc_cycles + 1;
            addr_seen  = wbm_address;
            data_seen  = wbm_writedata;
            we_seen    = wbm_write;
        end
        cyc_prev = wbm_cycle;
        if (!gpmc_wait) wait_cycles = wait_cycles + 1;
        if (bus_error) err_cycles = err_cycles + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input state_t s, input int max, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (dut.state_reg === s) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s timed out waiting for state %0d", tag, s);
        end
    endtask

    task automatic clear_mon();
        cyc_rises = 0; cyc_cycles = 0; wait_cycles = 0; err_cycles = 0;
        addr_seen = '0; data_seen = '0; we_seen = 1'b0;
    endtask

    task automatic gclk_pulse();
        gpmc_clk = 1'b1; tick(4);
        gpmc_clk = 1'b0; tick(4);
    endtask

    task automatic addr_phase(input logic [15:0] a);
        gpmc_csn = 1'b0; gpmc_advn = 1'b0; gpmc_ad_in = a;
        tick(4);
        gclk_pulse();
    endtask

    task automatic write_start(input logic [15:0] a, input logic [15:0] d);
        addr_phase(a);
        gpmc_advn = 1'b1; gpmc_wein = 1'b0; gpmc_ad_in = d;
        tick(4);
        gclk_pulse();
    endtask

    task automatic read_start(input logic [15:0] a);
        addr_phase(a);
        gpmc_advn = 1'b1; gpmc_oen = 1'b0;
    endtask

    task automatic end_access();
        gpmc_wein = 1'b1; gpmc_oen = 1'b1; gpmc_csn = 1'b1; gpmc_advn = 1'b1;
        tick(6);
    endtask

    initial begin
        clear_mon();
        // Reset state.
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_cyc",   32'(wbm_cycle), 32'd0);
        chk("rst_stb",   32'(wbm_strobe), 32'd0);
        chk("rst_we",    32'(wbm_write), 32'd0);
        chk("rst_addr",  32'(wbm_address), 32'h0);
        chk("rst_wdata", 32'(wbm_writedata), 32'h0);
        chk("rst_sel",   32'(wbm_sel), 32'h3);
        chk("rst_oe",    32'(gpmc_ad_oe), 32'd0);
        chk("rst_adout", 32'(gpmc_ad_out), 32'h0);
        chk("rst_wait",  32'(gpmc_wait), 32'd1);
        chk("rst_berr",  32'(bus_error), 32'd0);
        chk("rst_state", 32'(dut.state_reg), 32'(IDLE));

        // Write 0xA5A5 to 0x0042, ack on the third cycle.
        clear_mon(); slave_mode = 1; slave_lat = 3;
        write_start(16'h0042, 16'hA5A5);
        wait_state(DONE, 40, "wr_done");
        chk("wr_cycles", 32'(cyc_rises), 32'd1);
        chk("wr_len",    32'(cyc_cycles), 32'd3);
        chk("wr_addr",   32'(addr_seen), 32'h0042);
        chk("wr_data",   32'(data_seen), 32'hA5A5);
        chk("wr_we",     32'(we_seen), 32'd1);
        chk("wr_wait",   32'(wait_cycles), 32'd3);
        chk("wr_berr",   32'(err_cycles), 32'd0);
        end_access();
        chk("wr_idle",   32'(dut.state_reg), 32'(IDLE));

        // Read 0x0010, slave returns 0x1234 immediately.
        clear_mon(); slave_mode = 1; slave_lat = 1; wbm_readdata = 16'h1234;
        read_start(16'h0010);
        wait_state(RD_HOLD, 40, "rd_hold");
        chk("rd_data",   32'(gpmc_ad_out), 32'h1234);
        chk("rd_oe_on",  32'(gpmc_ad_oe), 32'd1);
        chk("rd_addr",   32'(addr_seen), 32'h0010);
        chk("rd_we",     32'(we_seen), 32'd0);
        chk("rd_len",    32'(cyc_cycles), 32'd1);
        tick(3);
        chk("rd_oe_hold", 32'(gpmc_ad_oe), 32'd1);
        gpmc_oen = 1'b1;
        tick(2);
        chk("rd_oe_lat",  32'(gpmc_ad_oe), 32'd1);
        tick(1);
        chk("rd_oe_off",  32'(gpmc_ad_oe), 32'd0);
        chk("rd_done",    32'(dut.state_reg), 32'(DONE));
        end_access();
        chk("rd_berr",   32'(err_cycles), 32'd0);
        chk("rd_keep",   32'(gpmc_ad_out), 32'h1234);

        // Read where ack and err arrive together: error data wins.
        clear_mon(); slave_mode = 3; slave_lat = 1; wbm_readdata = 16'h7777;
        read_start(16'h0011);
        wait_state(RD_HOLD, 40, "both_hold");
        chk("both_data", 32'(gpmc_ad_out), 32'hDEAD);
        end_access();
        chk("both_berr", 32'(err_cycles), 32'd1);

        // Write terminated by wbm_err on the second cycle.
        clear_mon(); slave_mode = 2; slave_lat = 2;
        write_start(16'h0030, 16'h5555);
        wait_state(DONE, 40, "err_done");
        chk("err_len",   32'(cyc_cycles), 32'd2);
        chk("err_we",    32'(we_seen), 32'd1);
        chk("err_wait",  32'(wait_cycles), 32'd2);
        end_access();
        chk("err_berr",  32'(err_cycles), 32'd1);
        chk("err_idle",  32'(dut.state_reg), 32'(IDLE));

        // Abort after the address phase: no bus cycle.
        clear_mon(); slave_mode = 1; slave_lat = 1;
        addr_phase(16'h0099);
        chk("abt_addr",  32'(dut.state_reg), 32'(ADDR));
        end_access();
        chk("abt_idle",  32'(dut.state_reg), 32'(IDLE));
        chk("abt_cyc",   32'(cyc_rises), 32'd0);

        // Reset in the middle of an unanswered read.
        clear_mon(); slave_mode = 0;
        read_start(16'h0055);
        wait_state(RD_REQ, 40, "mid_req");
        tick(2);
        chk("mid_cyc_pre", 32'(wbm_cycle), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("mid_cyc",   32'(wbm_cycle), 32'd0);
        chk("mid_stb",   32'(wbm_strobe), 32'd0);
        chk("mid_oe",    32'(gpmc_ad_oe), 32'd0);
        chk("mid_wait",  32'(gpmc_wait), 32'd1);
        chk("mid_state", 32'(dut.state_reg), 32'(IDLE));
        reset = 1'b0;
        end_access();

        // Normal write after the reset.
        clear_mon(); slave_mode = 1; slave_lat = 1;
        write_start(16'h0077, 16'hBEEF);
        wait_state(DONE, 40, "post_done");
        chk("post_cyc",  32'(cyc_rises), 32'd1);
        chk("post_addr", 32'(addr_seen), 32'h0077);
        chk("post_data", 32'(data_seen), 32'hBEEF);
        chk("post_wait", 32'(wait_cycles), 32'd1);
        end_access();
        chk("post_berr", 32'(err_cycles), 32'd0);
        chk("post_adout", 32'(gpmc_ad_out), 32'h0);

        // Read with no response: times out after 8 cycles.
        clear_mon(); slave_mode = 0;
        read_start(16'h0020);
        wait_state(RD_HOLD, 60, "to_hold");
        chk("to_len",    32'(cyc_cycles), 32'd8);
        chk("to_wait",   32'(wait_cycles), 32'd8);
        chk("to_data",   32'(gpmc_ad_out), 32'hDEAD);
        end_access();
        chk("to_berr",   32'(err_cycles), 32'd1);
        chk("to_idle",   32'(dut.state_reg), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpmc_wb_bridge_sync.md
Name: gpmc_wb_bridge_sync

Overview:
Second-generation GPMC-to-Wishbone master bridge. All GPMC inputs are oversampled and synchronised into the single clk domain, and a state machine runs a full Wishbone handshake: wait for ack, error and timeout. GPMC wait stalls the host until the slave responds. Sits between the BeagleBone GPMC pads (tristate pad cell instantiated at top level) and the FPGA Wishbone interconnect.

Parameters:
ADDR_WIDTH, 16, Wishbone address width; low ADDR_WIDTH bits of the muxed AD bus captured in address phase.
DATA_WIDTH, 16, GPMC AD and Wishbone data width (8 or 16).
SYNC_STAGES, 2, synchroniser depth for GPMC inputs (>=2).
TIMEOUT_CYCLES, 255, clk cycles without ack/err before timeout (>=1).
ERR_DATA, 16'hDEAD, read data returned on timeout or wbm_err (truncated to DATA_WIDTH).
WAIT_ACTIVE_LOW, 1, polarity of gpmc_wait (1: low = stall).

Ports:
clk  in  1  system clock; sole clock.
reset  in  1  synchronous, active-high reset.
gpmc_ad_in  in  DATA_WIDTH  AD bus from pad.
gpmc_ad_out  out  DATA_WIDTH  read data to pad.
gpmc_ad_oe  out  1  pad output enable.
gpmc_clk  in  1  GPMC clock, sampled as data.
gpmc_advn  in  1  low = address phase.
gpmc_csn  in  1  chip select, active low.
gpmc_wein  in  1  low = write.
gpmc_oen  in  1  low = read.
gpmc_wait  out  1  stall to host.
wbm_address  out  ADDR_WIDTH  Wishbone address.
wbm_writedata  out  DATA_WIDTH  write data.
wbm_readdata  in  DATA_WIDTH  read data.
wbm_sel  out  DATA_WIDTH/8  byte select, all ones.
wbm_write  out  1  high = write.
wbm_strobe  out  1  strobe.
wbm_cycle  out  1  cycle.
wbm_ack  in  1  slave ack.
wbm_err  in  1  slave error.
bus_error  out  1  one-cycle pulse on timeout or wbm_err.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- All GPMC inputs pass SYNC_STAGES flops. gclk_rise = synced gpmc_clk 0->1. Decisions use synced values only; input-to-decision latency is SYNC_STAGES+1 clk.
- Reset (sampled on clk edge): state IDLE; wbm_cycle/strobe/write=0; wbm_address/writedata=0; wbm_sel all ones; gpmc_ad_oe=0; gpmc_ad_out=0; gpmc_wait deasserted; bus_error=0; timeout counter=0. Reset mid-cycle drops cyc/stb on the next edge; no ack is waited for.
- States:
  - IDLE: csn=0, advn=0 and gclk_rise -> latch AD into wbm_address, go to ADDR.
  - ADDR: csn=1 -> IDLE (abort, no WB cycle). advn=1, wein=0 on gclk_rise -> latch AD into wbm_writedata, go to WR_REQ. advn=1, oen=0 -> RD_REQ. wein and oen both low -> write wins.
  - WR_REQ/RD_REQ: cyc=stb=1 (we=1 in WR_REQ only). Counter increments each cycle.
    - ack -> drop cyc/stb on the same edge. RD latches wbm_readdata into gpmc_ad_out.
    - err, or counter reaches TIMEOUT_CYCLES-1 without ack -> drop cyc/stb and pulse bus_error; RD loads ERR_DATA.
    - ack and err together -> treated as err.
    - Next state: WR_REQ -> DONE; RD_REQ -> RD_HOLD.
    - csn rising while in these states is ignored; the WB cycle always completes or times out.
  - RD_HOLD: gpmc_ad_oe=1 while synced csn=0 and oen=0. Either high -> oe=0 on the same edge, go to DONE.
  - DONE: wait for csn=1, then IDLE. Counter cleared.
- gpmc_wait is asserted on entry to WR_REQ/RD_REQ and deasserted when leaving them; it is registered.
- gpmc_ad_oe is never 1 outside RD_HOLD. gpmc_ad_out holds its value until the next read.
- wbm_address/writedata are stable for the whole WB cycle.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1) and it does not wrap.

Decomposition:
- Package gpmc_wb_pkg holds:
  - state enum: IDLE, ADDR, WR_REQ, RD_REQ, RD_HOLD, DONE;
  - default ERR_DATA;
  - clog2-based counter width function.
- Sub-module gpmc_in_sync: parametrised SYNC_STAGES synchroniser for the control bits and AD bus, with gpmc_clk rise detect.

Test Plan:
- Write: addr 0x0042, data 0xA5A5, ack after 3 cycles -> one cycle with we=1, addr 0x0042, data 0xA5A5; wait asserted exactly 3 cycles; bus_error=0.
- Read: addr 0x0010, slave returns 0x1234 with immediate ack -> gpmc_ad_out=0x1234; oe=1 only while oen low; oe=0 within SYNC_STAGES+1 cycles of oen high.
- Timeout: read, no ack, TIMEOUT_CYCLES=8 -> cyc drops after 8 cycles; bus_error pulses once; gpmc_ad_out=0xDEAD.
- wbm_err on write -> cycle ends; bus_error pulse; FSM reaches IDLE after csn high.
- Abort: csn high after address phase -> no WB cycle; state IDLE.
- Reset mid-read (cyc=1) -> next edge: cyc=stb=0, oe=0, wait deasserted; a subsequent write completes normally.
